arm_ctrl_mac: RTL

Transaction sequencer directly upstream of the ARM control SPI byte PHY.
- Accepts one register access request: read or write, 7-bit address, DATA_BYTES data bytes.
- Serialises the request into a command byte plus data bytes.
- For each byte, drives the PHY through its set/fire/done handshake and collects the received MISO bytes.
- Returns a single response with the assembled read data.
- Sits between the bench/host register model and the PHY in the ARM control path.

---
 rtl/arm_ctrl_pkg.sv | 14 +
 rtl/arm_ctrl_mac_wdog.sv | 34 +++
 rtl/arm_ctrl_mac.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared constants for the ARM control SPI transaction sequencer:
// FSM state encodings and command byte layout.
package arm_ctrl_pkg;

  localparam int ADDR_W     = 7;
  localparam int CMD_RW_BIT = 7;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

endpackage

// File: rtl/arm_ctrl_mac_wdog.sv
// Per-byte watchdog: cleared before each wait, counts wait cycles and flags
// expiry on the LIMIT-th cycle. Used only when ARM_CTRL_MAC_TIMEOUT_EN is set.
module arm_ctrl_mac_wdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expire)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/arm_ctrl_mac.sv
// Register-access sequencer in front of the ARM control SPI byte PHY.
// Optional per-byte timeout enabled by defining ARM_CTRL_MAC_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | ready for a request
// S_LOAD | present next byte to PHY (set_vld)
// S_FIRE | start PHY transfer (fire_cspi), advance tx shifter
// S_WAIT | wait for done_cspi, collect MISO byte
// S_RESP | one-cycle response pulse
module arm_ctrl_mac
  import arm_ctrl_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_vld,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [7:0]              set_data,
  output logic                    set_vld,
  output logic                    fire_cspi,
  input  logic                    done_cspi,
  input  logic [7:0]              get_q,
  input  logic                    get_vld
);

  localparam int TX_W = 8 * (DATA_BYTES + 1);
  localparam int RD_W = 8 * DATA_BYTES;

  logic [2:0]      state_q, state_d;
  logic [TX_W-1:0] tx_q, tx_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [2:0]      idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [7:0]      cmd_byte;
  logic            rdata_ok;

`ifdef ARM_CTRL_MAC_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_expire;

  arm_ctrl_mac_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (state_q == S_FIRE),
    .en      (state_q == S_WAIT),
    .expire  (wd_expire)
  );

  assign rsp_err  = (state_q == S_RESP) && err_q;
  assign rdata_ok = !wr_q && !err_q;
`else
  assign rsp_err  = 1'b0;
  assign rdata_ok = !wr_q;
`endif

  always_comb begin
    cmd_byte             = '0;
    cmd_byte[CMD_RW_BIT] = req_wr;
    cmd_byte[ADDR_W-1:0] = req_addr;
  end

  assign req_rdy   = (state_q == S_IDLE);
  assign busy      = !req_rdy;
  assign set_vld   = (state_q == S_LOAD);
  assign fire_cspi = (state_q == S_FIRE);
  assign rsp_vld   = (state_q == S_RESP);
  assign set_data  = set_vld ? tx_q[TX_W-1 -: 8] : 8'h00;
  assign rsp_rdata = (rsp_vld && rdata_ok) ? rd_q : '0;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
`ifdef ARM_CTRL_MAC_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          tx_d    = {cmd_byte, req_wdata};
          wr_d    = req_wr;
          idx_d   = '0;
          rd_d    = '0;
`ifdef ARM_CTRL_MAC_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_FIRE;
      S_FIRE: begin
        tx_d    = tx_q << 8;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_cspi) begin
          // byte 0 is the command byte; its MISO content is meaningless
          if (idx_q != 3'd0 && !wr_q && get_vld)
            rd_d = RD_W'({rd_q, get_q});
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'(DATA_BYTES)) ? S_RESP : S_LOAD;
        end
`ifdef ARM_CTRL_MAC_TIMEOUT_EN
        else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
`ifdef ARM_CTRL_MAC_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
`ifdef ARM_CTRL_MAC_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
